// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared transfer-FSM state encoding and IM/main-memory widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

  localparam int IM_AW  = 10;
  localparam int MEM_AW = 14;
  localparam int DW     = 32;
  localparam int SZW    = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } xfer_state_t;

endpackage

`default_nettype wire

// File: rtl/dump_checksum.sv
// ============================================================================
//  Module      : dump_checksum
//  Description : Modular sum of words written by the dump engine.
//                Present only when DUMP_CHECKSUM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef DUMP_CHECKSUM_EN
module dump_checksum
  import mem_ctrl_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          add_en,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] sum
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + data;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/im_dump_controller.sv
// ============================================================================
//  Module      : im_dump_controller
//  Description : Copies a block of words from instruction memory into main
//                memory. Optional checksum output under DUMP_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module im_dump_controller
  import mem_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              dump_start,
  input  logic [IM_AW-1:0]  dump_src_addr,
  input  logic [MEM_AW-1:0] dump_dst_addr,
  input  logic [SZW-1:0]    dump_size,
  input  logic [DW-1:0]     im_rdata,
  output logic              im_enable,
  output logic              im_en_read,
  output logic              im_en_write,
  output logic [IM_AW-1:0]  im_addr,
  output logic              mem_enable,
  output logic              mem_en_read,
  output logic              mem_en_write,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              dump_busy,
  output logic              dump_done
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [DW-1:0]     dump_checksum
`endif
);

  xfer_state_t       r_state;
  logic [IM_AW-1:0]  r_src;
  logic [MEM_AW-1:0] r_dst;
  logic [SZW-1:0]    r_count;

  assign im_en_write = 1'b0;
  assign mem_en_read = 1'b0;

  // Outputs are loaded on the edge entering the state they belong to.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_count      <= '0;
      im_enable    <= 1'b0;
      im_en_read   <= 1'b0;
      im_addr      <= '0;
      mem_enable   <= 1'b0;
      mem_en_write <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      dump_busy    <= 1'b0;
      dump_done    <= 1'b0;
    end else begin
      im_enable    <= 1'b0;
      im_en_read   <= 1'b0;
      mem_enable   <= 1'b0;
      mem_en_write <= 1'b0;
      dump_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (dump_start) begin
            r_src     <= dump_src_addr;
            r_dst     <= dump_dst_addr;
            r_count   <= dump_size;
            dump_busy <= 1'b1;
            if (dump_size != '0) begin
              r_state    <= RD;
              im_enable  <= 1'b1;
              im_en_read <= 1'b1;
              im_addr    <= dump_src_addr;
            end else begin
              r_state   <= DONE;
              dump_done <= 1'b1;
            end
          end
        end
        RD: begin
          r_state <= WAIT;
        end
        WAIT: begin
          r_state      <= WR;
          mem_wdata    <= im_rdata;
          mem_addr     <= r_dst;
          mem_enable   <= 1'b1;
          mem_en_write <= 1'b1;
        end
        WR: begin
          r_count <= r_count - 1'b1;
          r_src   <= r_src + 1'b1;
          r_dst   <= r_dst + 1'b1;
          if (r_count == {{(SZW-1){1'b0}}, 1'b1}) begin
            r_state   <= DONE;
            dump_done <= 1'b1;
          end else begin
            r_state    <= RD;
            im_enable  <= 1'b1;
            im_en_read <= 1'b1;
            im_addr    <= r_src + 1'b1;
          end
        end
        DONE: begin
          r_state   <= IDLE;
          dump_busy <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          dump_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef DUMP_CHECKSUM_EN
  dump_checksum u_dump_checksum (
    .clock  (clock),
    .reset  (reset),
    .clear  ((r_state == IDLE) && dump_start),
    .add_en (r_state == WR),
    .data   (mem_wdata),
    .sum    (dump_checksum)
  );
`endif

endmodule

`default_nettype wire
